// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one Hack data-memory port between requester A (CPU) and requester B
//   (DMA/screen/debug). Requests are arbitrated round-robin and exactly one
//   transaction is in flight at a time. The winning command is registered at
//   grant, so the memory side sees stable mem_we/mem_addr/mem_wdata for the
//   whole transaction. sel drives the downstream data mux (1 = A owns the bus).
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     a_req/a_we/a_addr/a_wdata  port A command, held until a_ack
//     a_ack, a_rdata             port A one-cycle completion, read data
//     b_*                        same as port A, for port B
//     mem_en                     one-cycle strobe per transaction
//     mem_we/mem_addr/mem_wdata  registered command of the current owner
//     mem_rdata                  memory read data, valid MEM_LAT cycles after mem_en
//     sel                        current/last owner (1 = A)
//     busy                       high whenever the FSM is not in IDLE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; grant and register command on entry
//   ISSUE | mem_en pulse; latency counter loaded
//   WAIT  | count down memory latency; capture read data at zero
//   DONE  | owner's ack pulse; requests ignored

module mem_bus_arbiter #(
  parameter int AW      = 15,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          sel,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // WAIT is entered one cycle after mem_en, so MEM_LAT-1 further cycles
  // put the capture exactly MEM_LAT cycles after the strobe.
  localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] cnt;
  logic       last_grant_a;   // 1 = A was granted last; reset to B so A wins the first tie
  logic       grant;
  logic       grant_a;
  logic       capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_a    = 1'b0;
    capture    = 1'b0;
    mem_en     = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (a_req || b_req) begin
          grant      = 1'b1;
          // A wins when alone, or on a tie when B was granted last.
          grant_a    = a_req && (!b_req || !last_grant_a);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        a_ack      = sel;
        b_ack      = !sel;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command, ownership and arbitration history change only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel          <= 1'b1;
      last_grant_a <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else if (grant) begin
      sel          <= grant_a;
      last_grant_a <= grant_a;
      if (grant_a) begin
        mem_we    <= a_we;
        mem_addr  <= a_addr;
        mem_wdata <= a_wdata;
      end else begin
        mem_we    <= b_we;
        mem_addr  <= b_addr;
        mem_wdata <= b_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (state == ISSUE) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  // Only the owner's read register moves, and only for reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (capture && !mem_we) begin
      if (sel) begin
        a_rdata <= mem_rdata;
      end else begin
        b_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;

  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        sel, busy;

  logic        a_req3;
  logic [14:0] a_addr3;
  logic        a_ack3, b_ack3;
  logic [15:0] a_rdata3, b_rdata3;
  logic        mem_en3, mem_we3;
  logic [14:0] mem_addr3;
  logic [15:0] mem_wdata3, mem_rdata3;
  logic        sel3, busy3;

  logic [11:0] cyc = '0;
  logic [15:0] rd_q = '0;
  logic [14:0] wr_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.AW(15), .DW(16), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sel(sel), .busy(busy)
  );

  mem_bus_arbiter #(.AW(15), .DW(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .a_req(a_req3), .a_we(1'b0), .a_addr(a_addr3), .a_wdata(16'h0000),
    .a_ack(a_ack3), .a_rdata(a_rdata3),
    .b_req(1'b0), .b_we(1'b0), .b_addr(15'h0000), .b_wdata(16'h0000),
    .b_ack(b_ack3), .b_rdata(b_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .sel(sel3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 12'd1;

  function automatic logic [15:0] ram_init(input logic [14:0] a);
    case (a)
      15'h0010: ram_init = 16'h1234;
      15'h0020: ram_init = 16'h2222;
      15'h0030: ram_init = 16'h3333;
      15'h0002: ram_init = 16'h00AA;
      default:  ram_init = 16'hDEAD;
    endcase
  endfunction

  // One-cycle-latency memory for the MEM_LAT=1 instance.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_addr_seen <= mem_addr;
        wr_data_seen <= mem_wdata;
      end else begin
        rd_q <= ram_init(mem_addr);
      end
    end
  end
  assign mem_rdata = rd_q;

  // Cycle-stamped data so the capture cycle of the MEM_LAT=3 instance is visible.
  assign mem_rdata3 = {4'hC, cyc};

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({a_ack, b_ack, mem_en, mem_we, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {a_ack, b_ack, mem_en, mem_we, busy});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, a_rdata, b_rdata} !== 63'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h ard %h brd %h expected all 0", mem_addr, mem_wdata, a_rdata, b_rdata);
    end
    n_checks++;
    if (sel !== 1'b1 || sel3 !== 1'b1 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sel: sel %b sel3 %b busy3 %b expected 1 1 0", sel, sel3, busy3);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({a_ack, b_ack, mem_en, busy, sel} !== 5'b00001) begin
        n_fail++;
        $display("FAIL idle_hold: got %b expected 00001", {a_ack, b_ack, mem_en, busy, sel});
      end
    end
  endtask

  task automatic test_read_a;
    a_we = 1'b0; a_addr = 15'h0010; a_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 15'h0010 || mem_we !== 1'b0 || sel !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_a_issue: en %b addr %h we %b sel %b busy %b expected 1 0010 0 1 1", mem_en, mem_addr, mem_we, sel, busy);
    end
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b0 || a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL read_a_wait: en %b ack %b expected 0 0", mem_en, a_ack);
    end
    @(negedge clk);
    n_checks++;
    if (a_ack !== 1'b1 || a_rdata !== 16'h1234 || b_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL read_a_done: ack %b rdata %h back %b expected 1 1234 0", a_ack, a_rdata, b_ack);
    end
    a_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_ack !== 1'b0 || busy !== 1'b0 || a_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL read_a_after: ack %b busy %b rdata %h expected 0 0 1234", a_ack, busy, a_rdata);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] grants;
    int ng;
    int na;
    int nb;
    grants = 4'b0; ng = 0; na = 0; nb = 0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    a_we = 1'b0; a_addr = 15'h0020; a_req = 1'b1;
    b_we = 1'b0; b_addr = 15'h0030; b_req = 1'b1;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (a_ack) na++;
      if (b_ack) nb++;
      if (mem_en) begin
        grants[3 - ng] = sel;
        ng++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 10 && busy; i++) begin
      @(negedge clk);
      if (a_ack) na++;
      if (b_ack) nb++;
    end
    n_checks++;
    if (ng !== 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants expected 4", ng);
    end
    n_checks++;
    if (grants !== 4'b1010) begin
      n_fail++;
      $display("FAIL rr_order: sel sequence %b expected 1010", grants);
    end
    n_checks++;
    if (na !== 2 || nb !== 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_acks: a %0d b %0d busy %b expected 2 2 0", na, nb, busy);
    end
    n_checks++;
    if (a_rdata !== 16'h2222 || b_rdata !== 16'h3333) begin
      n_fail++;
      $display("FAIL rr_rdata: a %h b %h expected 2222 3333", a_rdata, b_rdata);
    end
  endtask

  task automatic test_write_b;
    b_we = 1'b1; b_addr = 15'h4000; b_wdata = 16'hBEEF; b_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h4000 || mem_wdata !== 16'hBEEF || sel !== 1'b0) begin
      n_fail++;
      $display("FAIL write_b_issue: en %b we %b addr %h wdata %h sel %b expected 1 1 4000 beef 0", mem_en, mem_we, mem_addr, mem_wdata, sel);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (b_ack !== 1'b1 || a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL write_b_ack: b %b a %b expected 1 0", b_ack, a_ack);
    end
    n_checks++;
    if (a_rdata !== 16'h2222 || b_rdata !== 16'h3333) begin
      n_fail++;
      $display("FAIL write_b_rdata: a %h b %h expected 2222 3333", a_rdata, b_rdata);
    end
    b_req = 1'b0; b_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_addr_seen !== 15'h4000 || wr_data_seen !== 16'hBEEF || busy !== 1'b0 || b_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL write_b_mem: addr %h data %h busy %b ack %b expected 4000 beef 0 0", wr_addr_seen, wr_data_seen, busy, b_ack);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    got = 1'b0;
    a_we = 1'b0; a_addr = 15'h0010; a_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || mem_en !== 1'b0 || a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: busy %b en %b ack %b expected 1 0 0", busy, mem_en, a_ack);
    end
    reset = 1'b1; a_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (a_ack !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0 || sel !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_state: ack %b en %b busy %b sel %b expected 0 0 0 1", a_ack, mem_en, busy, sel);
    end
    n_checks++;
    if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_rdata: a %h b %h expected 0000 0000", a_rdata, b_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (a_ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_noack: ack %b busy %b expected 0 0", a_ack, busy);
    end
    b_we = 1'b0; b_addr = 15'h0002; b_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (b_ack) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL reset_mid_b_timeout: b_ack not seen in 10 cycles");
    end else if (b_rdata !== 16'h00AA || a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_b_read: rdata %h a_ack %b expected 00aa 0", b_rdata, a_ack);
    end
    b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency3;
    logic [11:0] c0;
    logic [15:0] got_data;
    int ack_at;
    ack_at = -1; got_data = '0;
    c0 = cyc;
    a_addr3 = 15'h0055; a_req3 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++;
        if (mem_en3 !== 1'b1 || mem_addr3 !== 15'h0055) begin
          n_fail++;
          $display("FAIL lat3_issue: en %b addr %h expected 1 0055", mem_en3, mem_addr3);
        end
      end
      if (a_ack3 && ack_at < 0) begin
        ack_at = i;
        got_data = a_rdata3;
        a_req3 = 1'b0;
      end
    end
    n_checks++;
    if (ack_at !== 5) begin
      n_fail++;
      $display("FAIL lat3_ack_cycle: got %0d expected 5", ack_at);
    end
    n_checks++;
    if (got_data !== {4'hC, c0 + 12'd4}) begin
      n_fail++;
      $display("FAIL lat3_rdata: got %h expected %h", got_data, {4'hC, c0 + 12'd4});
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    a_req3 = 1'b0; a_addr3 = '0;
    test_reset;
    test_read_a;
    test_round_robin;
    test_write_b;
    test_reset_mid;
    test_latency3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
